// File: rtl/regfile_pool_gen.sv
// Bus register file with an IDLE/LAUNCH/BUSY engine sequencer, sticky DONE/ERR and IRQ.
// Build option POOL_RF_SHADOW_EN: RW writes land in a staging bank committed to cfg_o at launch.
//   state  | meaning
//   IDLE   | engine stopped, waiting for a START write
//   LAUNCH | start_o pulse being issued
//   BUSY   | engine running, waiting for done_i
module regfile_pool_gen #(
  parameter int              DW   = 16,
  parameter int              AW   = 14,
  parameter logic [AW-1:0]   BASE = 14'h200,
  parameter int              N_RW = 8,
  parameter int              N_RO = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        write_data,
  output logic [DW-1:0]        read_data_POOL,
  output logic [N_RW*DW-1:0]   cfg_o,
  input  logic [N_RO*DW-1:0]   sts_i,
  output logic                 start_o,
  input  logic                 done_i,
  output logic                 busy_o,
  output logic                 irq_o
);

  localparam logic [AW-1:0] A_CTRL = BASE;
  localparam logic [AW-1:0] A_RW0  = BASE + AW'(1);
  localparam logic [AW-1:0] A_RO0  = BASE + AW'(1 + N_RW);
  localparam logic [AW-1:0] A_STS  = BASE + AW'(1 + N_RW + N_RO);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

  state_t                   state_q, state_d;
  logic [N_RW-1:0][DW-1:0]  rw_q;
  logic [N_RO-1:0][DW-1:0]  ro_q;
  logic                     irq_en_q, done_q, err_q;
  logic                     irq_en_d, done_d, err_d;
  logic                     done_set, err_set;
  logic [N_RW-1:0]          rw_hit;
  logic                     rw_wr, wr_ctrl, wr_sts, start_req, abort_req;

  always_comb begin
    rw_hit = '0;
    for (int k = 0; k < N_RW; k++) rw_hit[k] = (addr == A_RW0 + AW'(k));
  end

  assign rw_wr     = wr_en && (|rw_hit);
  assign wr_ctrl   = wr_en && (addr == A_CTRL);
  assign wr_sts    = wr_en && (addr == A_STS);
  assign start_req = wr_ctrl && write_data[0];
  assign abort_req = wr_ctrl && write_data[2];
  assign busy_o    = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    err_set  = 1'b0;
    if (abort_req) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (start_req) state_d = LAUNCH;
        LAUNCH: begin
          state_d = BUSY;
          err_set = start_req;
        end
        BUSY: begin
          err_set = start_req;
          if (done_i) begin
            state_d  = IDLE;
            done_set = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifndef POOL_RF_SHADOW_EN
    // Single bank: config must not move under a running engine.
    if (rw_wr && (state_q != IDLE)) err_set = 1'b1;
`endif
  end

  // Set wins over a same-cycle write-1-to-clear.
  assign done_d   = done_set | (done_q & ~(wr_sts & write_data[1]));
  assign err_d    = err_set  | (err_q  & ~(wr_sts & write_data[2]));
  assign irq_en_d = wr_ctrl ? write_data[1] : irq_en_q;

`ifdef POOL_RF_SHADOW_EN
  logic [N_RW-1:0][DW-1:0] cfg_q;
  assign cfg_o = cfg_q;
`else
  assign cfg_o = rw_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rw_q     <= '0;
      ro_q     <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      start_o  <= 1'b0;
      irq_o    <= 1'b0;
`ifdef POOL_RF_SHADOW_EN
      cfg_q    <= '0;
`endif
    end else begin
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      start_o  <= (state_q == LAUNCH);
      irq_o    <= done_d & irq_en_d;
      if (done_set) ro_q <= sts_i;
      for (int k = 0; k < N_RW; k++) begin
`ifdef POOL_RF_SHADOW_EN
        if (wr_en && rw_hit[k]) rw_q[k] <= write_data;
`else
        if (wr_en && rw_hit[k] && (state_q == IDLE)) rw_q[k] <= write_data;
`endif
      end
`ifdef POOL_RF_SHADOW_EN
      if ((state_q == IDLE) && (state_d == LAUNCH)) cfg_q <= rw_q;
`endif
    end
  end

  always_comb begin
    read_data_POOL = '0;
    if (rd_en) begin
      if (addr == A_CTRL) read_data_POOL[1] = irq_en_q;
      if (addr == A_STS)  read_data_POOL[2:0] = {err_q, done_q, busy_o};
      for (int k = 0; k < N_RW; k++)
        if (rw_hit[k]) read_data_POOL = rw_q[k];
      for (int j = 0; j < N_RO; j++)
        if (addr == A_RO0 + AW'(j)) read_data_POOL = ro_q[j];
    end
  end

endmodule

// File: tb/tb_regfile_pool_gen.sv
// Directed self-checking bench for regfile_pool_gen; honours POOL_RF_SHADOW_EN when defined.
module tb_regfile_pool_gen;
  localparam int DW   = 16;
  localparam int AW   = 14;
  localparam int N_RW = 8;
  localparam int N_RO = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                wr_en = 1'b0;
  logic                rd_en = 1'b0;
  logic                done_i = 1'b0;
  logic [AW-1:0]       addr = '0;
  logic [DW-1:0]       write_data = '0;
  logic [DW-1:0]       read_data_POOL;
  logic [N_RW*DW-1:0]  cfg_o;
  logic [N_RO*DW-1:0]  sts_i = '0;
  logic                start_o, busy_o, irq_o;
  int                  n_cmp = 0;
  int                  n_err = 0;
  int                  n_start;

  always #5 clk = ~clk;

  regfile_pool_gen dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .write_data(write_data), .read_data_POOL(read_data_POOL), .cfg_o(cfg_o),
    .sts_i(sts_i), .start_o(start_o), .done_i(done_i), .busy_o(busy_o), .irq_o(irq_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a;
    write_data = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [AW-1:0] a, input logic [15:0] exp);
    addr = a;
    rd_en = 1'b1;
    #1;
    check(tag, read_data_POOL, exp);
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", 16'(busy_o), 16'd0);
    check("rst_start", 16'(start_o), 16'd0);
    check("rst_irq", 16'(irq_o), 16'd0);
    rst = 1'b1;
    check_rd("rst_sts", 14'h20E, 16'h0000);
    check_rd("rst_rw0", 14'h201, 16'h0000);

    // config, launch, start_o timing
    bus_write(14'h201, 16'h0020);
    bus_write(14'h208, 16'hFFFF);
    check_rd("rw0_rd", 14'h201, 16'h0020);
    check_rd("rw7_rd", 14'h208, 16'hFFFF);
    bus_write(14'h200, 16'h0001);
    check("busy_launch", 16'(busy_o), 16'd1);
    check("start_early", 16'(start_o), 16'd0);
    tick();
    check("start_pulse", 16'(start_o), 16'd1);
    tick();
    check("start_drop", 16'(start_o), 16'd0);
    check("cfg_w0", cfg_o[15:0], 16'h0020);
    check("cfg_w7", cfg_o[127:112], 16'hFFFF);
    check_rd("sts_busy", 14'h20E, 16'h0001);
    check_rd("ctrl_rd0", 14'h200, 16'h0000);
    addr = 14'h20E;
    rd_en = 1'b0;
    #1;
    check("rd_en_low", read_data_POOL, 16'h0000);

    // done, snapshot, W1C
    sts_i = {16'hA5A5, 48'h0, 16'h0010};
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    sts_i = {5{16'hBEEF}};
    check("busy_after_done", 16'(busy_o), 16'd0);
    check_rd("sts_done", 14'h20E, 16'h0002);
    check_rd("ro0_snap", 14'h209, 16'h0010);
    check_rd("ro4_snap", 14'h20D, 16'hA5A5);
    bus_write(14'h20E, 16'h0002);
    check_rd("sts_w1c", 14'h20E, 16'h0000);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check_rd("done_idle_ign", 14'h20E, 16'h0000);

    // START while busy, then abort with coincident done_i
    bus_write(14'h200, 16'h0001);
    tick();
    check("start_pulse2", 16'(start_o), 16'd1);
    bus_write(14'h200, 16'h0001);
    n_start = 0;
    repeat (4) begin
      n_start += int'(start_o);
      tick();
    end
    check("no_second_start", 16'(n_start), 16'd0);
    check_rd("sts_err_busy", 14'h20E, 16'h0005);
    addr = 14'h200;
    write_data = 16'h0005;
    wr_en = 1'b1;
    done_i = 1'b1;
    tick();
    wr_en = 1'b0;
    done_i = 1'b0;
    check("abort_busy", 16'(busy_o), 16'd0);
    check_rd("abort_no_done", 14'h20E, 16'h0004);
    tick();
    check("abort_no_start", 16'(start_o), 16'd0);
    bus_write(14'h20E, 16'h0004);
    check_rd("err_w1c", 14'h20E, 16'h0000);

    // interrupt and set-over-clear
    bus_write(14'h200, 16'h0002);
    check_rd("ctrl_irqen", 14'h200, 16'h0002);
    bus_write(14'h200, 16'h0003);
    tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("irq_set", 16'(irq_o), 16'd1);
    check_rd("sts_done2", 14'h20E, 16'h0002);
    bus_write(14'h200, 16'h0003);
    tick();
    addr = 14'h20E;
    write_data = 16'h0002;
    wr_en = 1'b1;
    done_i = 1'b1;
    tick();
    wr_en = 1'b0;
    done_i = 1'b0;
    check_rd("set_over_clr", 14'h20E, 16'h0002);
    check("irq_hold", 16'(irq_o), 16'd1);
    bus_write(14'h20E, 16'h0002);
    check("irq_clr", 16'(irq_o), 16'd0);
    check_rd("sts_clr2", 14'h20E, 16'h0000);

    // RW write while busy
    bus_write(14'h200, 16'h0003);
    tick();
    bus_write(14'h202, 16'h1234);
    check("cfg_w1_hold", cfg_o[31:16], 16'h0000);
`ifdef POOL_RF_SHADOW_EN
    check_rd("rw1_staged", 14'h202, 16'h1234);
    check_rd("sts_no_err", 14'h20E, 16'h0001);
`else
    check_rd("rw1_dropped", 14'h202, 16'h0000);
    check_rd("sts_rw_err", 14'h20E, 16'h0005);
`endif
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    bus_write(14'h20E, 16'h0006);
    bus_write(14'h200, 16'h0001);
`ifdef POOL_RF_SHADOW_EN
    check("cfg_w1_commit", cfg_o[31:16], 16'h1234);
`else
    check("cfg_w1_unchanged", cfg_o[31:16], 16'h0000);
`endif
    tick();
    check("busy_before_rst", 16'(busy_o), 16'd1);

    // reset during BUSY
    rst = 1'b0;
    tick();
    check("rst_busy_drop", 16'(busy_o), 16'd0);
    check("rst_start_drop", 16'(start_o), 16'd0);
    check("rst_cfg_zero", 16'(|cfg_o), 16'd0);
    check_rd("rst_rd_ctrl", 14'h200, 16'h0000);
    check_rd("rst_rd_rw0", 14'h201, 16'h0000);
    check_rd("rst_rd_ro0", 14'h209, 16'h0000);
    check_rd("rst_rd_ro4", 14'h20D, 16'h0000);
    check_rd("rst_rd_sts", 14'h20E, 16'h0000);
    rst = 1'b1;
    tick();

    // unmapped addresses
    bus_write(14'h20F, 16'hFFFF);
    check_rd("unmapped_hi", 14'h20F, 16'h0000);
    check_rd("unmapped_lo", 14'h1FF, 16'h0000);
    check_rd("sts_after_unmapped", 14'h20E, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_pool_gen.md
REGFILE_POOL_GEN -- requirements
Module: regfile_pool_gen

Interface
REQ-001 SHALL have parameter DW, default 16: register/data width.
REQ-002 SHALL have parameter AW, default 14: address width.
REQ-003 SHALL have parameter BASE, default 14'h200: block base address.
REQ-004 SHALL have parameter N_RW, default 8: number of RW config registers.
REQ-005 SHALL have parameter N_RO, default 5: number of RO status registers.
REQ-006 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1: reset; synchronous, active-low.
REQ-008 SHALL have ports wr_en and rd_en  input  1 each: bus write strobe and bus read enable.
REQ-009 SHALL have ports addr (input, AW), write_data (input, DW) and read_data_POOL (output, DW): bus address, write data and read data.
REQ-010 SHALL have port cfg_o  output  N_RW*DW: active config; register k at bits [k*DW +: DW].
REQ-011 SHALL have port sts_i  input  N_RO*DW: engine status words.
REQ-012 SHALL have ports start_o (output, 1), done_i (input, 1), busy_o (output, 1) and irq_o (output, 1): launch pulse, engine completion pulse, busy flag and interrupt.

Function
REQ-013 SHALL decode the map as follows:
- CTRL at BASE+0.
- RW k at BASE+1+k.
- RO j at BASE+1+N_RW+j.
- STATUS at BASE+1+N_RW+N_RO.
- Others: reads return 0, writes are ignored.
REQ-014 SHALL implement CTRL bits:
- bit0 START: write-1 requests a launch; reads 0.
- bit1 IRQ_EN: RW.
- bit2 ABORT: write-1 forces IDLE; reads 0.
REQ-015 SHALL implement STATUS bits:
- bit0 BUSY: RO.
- bit1 DONE: sticky, write-1-to-clear.
- bit2 ERR: sticky, write-1-to-clear.
- Upper bits read 0.
REQ-016 SHALL drive read_data_POOL combinationally from addr when rd_en=1, and 0 when rd_en=0.
REQ-017 SHALL implement FSM states IDLE, LAUNCH and BUSY.
REQ-018 SHALL, in IDLE, on a START write, go to LAUNCH next cycle.
REQ-019 SHALL, in LAUNCH, assert start_o for exactly one cycle, then go to BUSY.
REQ-020 SHALL, in BUSY, on done_i=1, go to IDLE and set DONE.
REQ-021 SHALL ignore done_i in IDLE and LAUNCH.
REQ-022 SHALL hold busy_o=1 in LAUNCH and BUSY.
REQ-023 SHALL, on a START write in LAUNCH or BUSY, ignore the start and set ERR.
REQ-024 SHALL, on an ABORT write, go to IDLE next cycle without setting DONE; ABORT has priority over START and done_i in the same write.
REQ-025 SHALL, when a DONE/ERR set and a W1C clear coincide in one cycle, give set priority.
REQ-026 SHALL snapshot sts_i into the RO registers in the cycle DONE is set; RO reads return the snapshot.
REQ-027 SHALL drive irq_o = DONE & IRQ_EN as a registered output.
REQ-028 SHALL pass write_data to registers without truncation or extension (all fields DW wide).

Reset
REQ-029 SHALL, while rst=0 at a clk edge, reset:
- FSM to IDLE.
- All RW, shadow and RO registers, CTRL and STATUS to 0.
- start_o, busy_o and irq_o to 0.
REQ-030 SHALL, if reset is asserted mid-LAUNCH or mid-BUSY, drop start_o and busy_o in the next cycle and perform no launch.

Configuration
REQ-031 SHALL use the macro POOL_RF_SHADOW_EN to select the config buffering mode.
REQ-032 SHALL, with POOL_RF_SHADOW_EN defined, behave as follows:
- RW writes go to a staging bank in any state.
- The staging bank is copied to cfg_o on the IDLE->LAUNCH edge.
- RW reads return staging.
REQ-033 SHALL, without POOL_RF_SHADOW_EN defined, behave as follows:
- Single bank; cfg_o equals the RW registers.
- RW writes in LAUNCH or BUSY are dropped and set ERR.

Verification
REQ-034 SHALL cover: write 0x201=0x0020, write 0x200=0x0001 -> start_o high exactly 2 cycles later for 1 cycle; cfg_o[15:0]=0x0020; read 0x20E=0x0001.
REQ-035 SHALL cover: in BUSY, sts_i word0=0x0010 and done_i pulse -> read 0x20E=0x0002, read 0x209=0x0010; then write 0x20E=0x0002 -> 0x20E reads 0x0000.
REQ-036 SHALL cover: START written while BUSY -> no second start_o; 0x20E reads 0x0005.
REQ-037 SHALL cover: IRQ_EN=1 (0x200=0x0002), launch, done_i -> irq_o=1; W1C of DONE coinciding with a new done_i -> DONE stays 1.
REQ-038 SHALL cover, with POOL_RF_SHADOW_EN defined: write 0x202=0x1234 while BUSY -> cfg_o unchanged until next launch, then word1=0x1234; without the macro -> write dropped, ERR=1.
REQ-039 SHALL cover: rst=0 during BUSY -> busy_o=0 after next edge, all reads return 0.
